// File: rtl/sys_pkg.sv
// Shared constants for the system controller: command opcodes, FSM state
// encoding and the register-file addresses that receive ALU operands.
package sys_pkg;

  localparam logic [7:0] CMD_WRITE     = 8'hAA;
  localparam logic [7:0] CMD_READ      = 8'hBB;
  localparam logic [7:0] CMD_ALU_OPS   = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOOPS = 8'hDD;

  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] ST_IDLE     = 4'd0;
  localparam logic [STATE_W-1:0] ST_WR_ADDR  = 4'd1;
  localparam logic [STATE_W-1:0] ST_WR_DATA  = 4'd2;
  localparam logic [STATE_W-1:0] ST_RD_ADDR  = 4'd3;
  localparam logic [STATE_W-1:0] ST_RD_WAIT  = 4'd4;
  localparam logic [STATE_W-1:0] ST_ALU_A    = 4'd5;
  localparam logic [STATE_W-1:0] ST_ALU_B    = 4'd6;
  localparam logic [STATE_W-1:0] ST_ALU_FUN  = 4'd7;
  localparam logic [STATE_W-1:0] ST_ALU_WAIT = 4'd8;
  localparam logic [STATE_W-1:0] ST_TX_BYTE0 = 4'd9;
  localparam logic [STATE_W-1:0] ST_TX_BYTE1 = 4'd10;

  localparam int unsigned OPERAND_A_ADDR = 0;
  localparam int unsigned OPERAND_B_ADDR = 1;

endpackage

// File: rtl/sys_ctrl.sv
// UART-driven system controller: decodes command frames into register-file
// and ALU operations and serialises the responses into the TX FIFO.
module sys_ctrl
  import sys_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_Valid,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    OUT_VALID,
  input  logic                    FIFO_FULL,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  output logic                    CLK_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD
);

  logic [STATE_W-1:0]      state_q,   state_d;
  logic [ADDR_WIDTH-1:0]   addr_q,    addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    wr_en_q,   wr_en_d;
  logic                    rd_en_q,   rd_en_d;
  logic                    alu_en_q,  alu_en_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic                    clk_en_q,  clk_en_d;
  logic [2*DATA_WIDTH-1:0] resp_q,    resp_d;
  logic                    resp_two_q, resp_two_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_vld_q,  tx_vld_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
    state_d    = state_q;
    addr_d     = addr_q;
    wr_data_d  = wr_data_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    alu_fun_d  = alu_fun_q;
    clk_en_d   = clk_en_q;
    resp_d     = resp_q;
    resp_two_d = resp_two_q;
    tx_data_d  = tx_data_q;
    tx_vld_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == DATA_WIDTH'(CMD_WRITE)) begin
            state_d = ST_WR_ADDR;
          end else if (RX_P_DATA == DATA_WIDTH'(CMD_READ)) begin
            state_d = ST_RD_ADDR;
          end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OPS)) begin
            state_d  = ST_ALU_A;
            clk_en_d = 1'b1;
          end else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NOOPS)) begin
            state_d  = ST_ALU_FUN;
            clk_en_d = 1'b1;
          end
        end
      end

      ST_WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = ST_WR_DATA;
        end
      end

      ST_WR_DATA: begin
        if (RX_D_VLD) begin
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      ST_RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d = 1'b1;
          state_d = ST_RD_WAIT;
        end
      end

      ST_RD_WAIT: begin
        if (RdData_Valid) begin
          resp_d     = {{DATA_WIDTH{1'b0}}, RdData};
          resp_two_d = 1'b0;
          state_d    = ST_TX_BYTE0;
        end
      end

      ST_ALU_A: begin
        if (RX_D_VLD) begin
          addr_d    = ADDR_WIDTH'(OPERAND_A_ADDR);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_ALU_B;
        end
      end

      ST_ALU_B: begin
        if (RX_D_VLD) begin
          addr_d    = ADDR_WIDTH'(OPERAND_B_ADDR);
          wr_data_d = RX_P_DATA;
          wr_en_d   = 1'b1;
          state_d   = ST_ALU_FUN;
        end
      end

      ST_ALU_FUN: begin
        if (RX_D_VLD) begin
          alu_fun_d = RX_P_DATA[3:0];
          alu_en_d  = 1'b1;
          state_d   = ST_ALU_WAIT;
        end
      end

      // The ALU clock stays enabled through the cycle its result is sampled.
      ST_ALU_WAIT: begin
        if (OUT_VALID) begin
          resp_d     = ALU_OUT;
          resp_two_d = 1'b1;
          clk_en_d   = 1'b0;
          state_d    = ST_TX_BYTE0;
        end
      end

      ST_TX_BYTE0: begin
        if (!FIFO_FULL) begin
          tx_data_d = resp_q[DATA_WIDTH-1:0];
          tx_vld_d  = 1'b1;
          state_d   = resp_two_q ? ST_TX_BYTE1 : ST_IDLE;
        end
      end

      ST_TX_BYTE1: begin
        if (!FIFO_FULL) begin
          tx_data_d = resp_q[2*DATA_WIDTH-1:DATA_WIDTH];
          tx_vld_d  = 1'b1;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      alu_en_q   <= 1'b0;
      alu_fun_q  <= '0;
      clk_en_q   <= 1'b0;
      resp_q     <= '0;
      resp_two_q <= 1'b0;
      tx_data_q  <= '0;
      tx_vld_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      alu_en_q   <= alu_en_d;
      alu_fun_q  <= alu_fun_d;
      clk_en_q   <= clk_en_d;
      resp_q     <= resp_d;
      resp_two_q <= resp_two_d;
      tx_data_q  <= tx_data_d;
      tx_vld_q   <= tx_vld_d;
    end
  end

  assign WrEn      = wr_en_q;
  assign RdEn      = rd_en_q;
  assign Address   = addr_q;
  assign WrData    = wr_data_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_FUN   = alu_fun_q;
  assign CLK_EN    = clk_en_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;

endmodule

// File: doc/sys_ctrl.md
SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning frame/register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, meaning register-file address width.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port RX_P_DATA  input  DATA_WIDTH  received byte from UART RX.
REQ-006 SHALL have port RX_D_VLD  input  1  one-cycle pulse qualifying RX_P_DATA.
REQ-007 SHALL have ports RdData input DATA_WIDTH and RdData_Valid input 1: register-file read result and its one-cycle qualifier.
REQ-008 SHALL have ports ALU_OUT input 2*DATA_WIDTH and OUT_VALID input 1: ALU result and its one-cycle qualifier.
REQ-009 SHALL have port FIFO_FULL  input  1  TX FIFO cannot accept a byte.
REQ-010 SHALL have ports WrEn output 1, RdEn output 1, Address output ADDR_WIDTH and WrData output DATA_WIDTH: register-file command.
REQ-011 SHALL have ports ALU_EN output 1, ALU_FUN output 4 and CLK_EN output 1: ALU enable, function select and ALU clock-gate enable.
REQ-012 SHALL have ports TX_P_DATA output DATA_WIDTH and TX_D_VLD output 1: byte pushed to the TX FIFO.

Function
REQ-013 SHALL decode the first byte after IDLE as a command: 0xAA write, 0xBB read, 0xCC ALU with operands, 0xDD ALU without operands; any other byte is dropped and the block stays IDLE.
REQ-014 SHALL use states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_BYTE0, TX_BYTE1; each byte-collecting state advances only on RX_D_VLD.
REQ-015 SHALL handle write as 0xAA, addr, data: on the data byte, assert WrEn for exactly one cycle with the latched Address and WrData = data, then go to IDLE; no TX response.
REQ-016 SHALL handle read as 0xBB, addr: on the addr byte, assert RdEn for exactly one cycle, then wait in RD_WAIT for RdData_Valid, latch RdData, and send one byte.
REQ-017 SHALL handle 0xCC, A, B, fun by writing A to address 0 and B to address 1, each as a one-cycle WrEn on receipt, then handling fun as for 0xDD.
REQ-018 SHALL handle 0xDD, fun by driving ALU_FUN = fun[3:0] and ALU_EN for exactly one cycle on receipt, then waiting in ALU_WAIT for OUT_VALID, latching ALU_OUT, and sending two bytes, LSB first.
REQ-019 SHALL hold CLK_EN high from command byte 0xCC/0xDD until the cycle OUT_VALID is sampled, inclusive.
REQ-020 SHALL pulse TX_D_VLD for one cycle per byte, only in a cycle with FIFO_FULL low; while FIFO_FULL is high, hold the state with TX_P_DATA stable and TX_D_VLD low.
REQ-021 SHALL drive TX_P_DATA and TX_D_VLD from registers, with the first TX_D_VLD no earlier than one cycle after the response is latched.
REQ-022 SHALL ignore RX_D_VLD while in RD_WAIT, ALU_WAIT or TX states; bytes arriving then are dropped.
REQ-023 SHALL ignore a RdData_Valid or OUT_VALID that arrives outside its wait state.
REQ-024 SHALL truncate Address to the low ADDR_WIDTH bits of the address byte.

Reset
REQ-025 SHALL on rst low, immediately and at any point in a transaction, force state IDLE and drive all outputs to 0, including WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD, Address, WrData, ALU_FUN and TX_P_DATA.
REQ-026 SHALL clear all latched operands and responses on reset; a partial command is discarded.

Structure
REQ-027 SHALL place command opcodes, the state encoding and the operand addresses (0, 1) as constants in a shared package sys_pkg.
REQ-028 SHALL be a single module with no sub-modules; response serialisation stays inline.

Verification
REQ-029 SHALL verify write: AA,05,3C -> one-cycle WrEn, Address=5, WrData=0x3C; no TX_D_VLD.
REQ-030 SHALL verify read: BB,07, then RdData=0x9E valid -> one RdEn with Address=7, then one TX_D_VLD with TX_P_DATA=0x9E.
REQ-031 SHALL verify ALU with operands: CC,0A,03,00, then ALU_OUT=0x000D -> WrEn at addr 0 and 1, one ALU_EN with FUN=0, then TX bytes 0x0D then 0x00.
REQ-032 SHALL verify backpressure: FIFO_FULL high for 5 cycles during a 0xDD response -> no TX_D_VLD while full, and both bytes later delivered in order, exactly once.
REQ-033 SHALL verify unknown opcode and reset: byte 0x55 -> stays IDLE with outputs 0; rst low after AA,05 -> IDLE, and a following 05 is not taken as data.
